// File: rtl/page_alloc_arbiter_if.sv
// Signal bundle linking the page allocation arbiter to its write requesters, release source and page-state block.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface page_alloc_arbiter_if;
  logic        arb_en;
  logic [15:0] wr_req;
  logic [15:0] wr_grant;
  logic [10:0] grant_page;
  logic        rel_valid;
  logic [3:0]  rel_port;
  logic [10:0] rel_addr;
  logic        rel_ready;
  logic        wr_op;
  logic [3:0]  wr_port;
  logic        rd_op;
  logic [3:0]  rd_port;
  logic [10:0] rd_addr;
  logic [3:0]  request_port;
  logic [10:0] page_amount;
  logic [10:0] null_ptr;
  logic [10:0] free_space;
  logic [1:0]  arb_state;

  modport slave (
    input  arb_en, wr_req, rel_valid, rel_port, rel_addr, page_amount, null_ptr, free_space,
    output wr_grant, grant_page, rel_ready, wr_op, wr_port, rd_op, rd_port, rd_addr,
           request_port, arb_state
  );

  modport master (
    output arb_en, wr_req, rel_valid, rel_port, rel_addr, page_amount, null_ptr, free_space,
    input  wr_grant, grant_page, rel_ready, wr_op, wr_port, rd_op, rd_port, rd_addr,
           request_port, arb_state
  );
endinterface

// File: rtl/page_alloc_arbiter.sv
// Round-robin page allocator for 16 write ports with per-port quota and free-page reserve.
// Grant and release strobes appear one cycle after acceptance; releases are always accepted, grants only in ACTIVE.
module page_alloc_arbiter #(
  parameter logic [10:0] PORT_QUOTA   = 11'd1024,
  parameter logic [10:0] FREE_RESERVE = 11'd0
) (
  input logic                 clk,
  input logic                 rst_n,
  page_alloc_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_rr_ptr, w_rr_nxt;
  logic        r_wr_op, r_rd_op;
  logic [3:0]  r_wr_port, r_rd_port;
  logic [10:0] r_rd_addr;

  logic [31:0] w_req_dbl;
  logic [15:0] w_req_rot;
  logic [3:0]  w_off, w_cand;
  logic        w_cand_vld;
  logic [11:0] w_free_sum, w_eff_free, w_amt_sum, w_eff_amount;
  logic        w_amt_inc, w_amt_dec, w_free_ok, w_quota_ok, w_any_req;
  logic        w_grant, w_adv;

  // Rotate so bit 0 is the port at rr_ptr; the lowest set bit is then the candidate offset.
  assign w_req_dbl = {bus.wr_req, bus.wr_req};
  assign w_req_rot = 16'(w_req_dbl >> r_rr_ptr);

  always_comb begin
    w_off      = 4'd0;
    w_cand_vld = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_off      = 4'(i);
        w_cand_vld = 1'b1;
      end
    end
  end

  assign w_cand = r_rr_ptr + w_off;

  // Free count and page count lag our own strobes by one edge, so fold the in-flight ops in.
  assign w_free_sum   = {1'b0, bus.free_space} + {11'd0, r_rd_op};
  assign w_eff_free   = (r_wr_op && w_free_sum == 12'd0) ? 12'd0 : w_free_sum - {11'd0, r_wr_op};
  assign w_amt_inc    = r_wr_op && (r_wr_port == w_cand);
  assign w_amt_dec    = r_rd_op && (r_rd_port == w_cand);
  assign w_amt_sum    = {1'b0, bus.page_amount} + {11'd0, w_amt_inc};
  assign w_eff_amount = (w_amt_dec && w_amt_sum == 12'd0) ? 12'd0 : w_amt_sum - {11'd0, w_amt_dec};
  assign w_free_ok    = w_eff_free > {1'b0, FREE_RESERVE};
  assign w_quota_ok   = w_eff_amount < {1'b0, PORT_QUOTA};
  assign w_any_req    = |bus.wr_req;

  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_grant     = 1'b0;
    // A candidate at quota still moves the pointer so it cannot starve the others.
    if (r_state == ST_ACTIVE && bus.arb_en && w_cand_vld && w_free_ok) begin
      w_adv   = 1'b1;
      w_grant = w_quota_ok;
    end
    if (!bus.arb_en) begin
      w_state_nxt = ST_HOLD;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_any_req) w_state_nxt = ST_ACTIVE;
        ST_ACTIVE: begin
          if (!w_any_req)      w_state_nxt = ST_IDLE;
          else if (!w_free_ok) w_state_nxt = ST_FULL;
        end
        ST_FULL:   if (w_free_ok) w_state_nxt = w_any_req ? ST_ACTIVE : ST_IDLE;
        ST_HOLD:   w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_rr_nxt = w_adv ? (w_cand + 4'd1) : r_rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= 4'd0;
      r_wr_op   <= 1'b0;
      r_wr_port <= 4'd0;
      r_rd_op   <= 1'b0;
      r_rd_port <= 4'd0;
      r_rd_addr <= 11'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_wr_op   <= w_grant;
      r_wr_port <= w_grant ? w_cand : 4'd0;
      r_rd_op   <= bus.rel_valid;
      r_rd_port <= bus.rel_valid ? bus.rel_port : 4'd0;
      r_rd_addr <= bus.rel_valid ? bus.rel_addr : 11'd0;
    end
  end

  assign bus.wr_grant     = r_wr_op ? (16'd1 << r_wr_port) : 16'd0;
  assign bus.grant_page   = r_wr_op ? bus.null_ptr : 11'd0;
  assign bus.rel_ready    = rst_n;
  assign bus.wr_op        = r_wr_op;
  assign bus.wr_port      = r_wr_port;
  assign bus.rd_op        = r_rd_op;
  assign bus.rd_port      = r_rd_port;
  assign bus.rd_addr      = r_rd_addr;
  assign bus.request_port = w_cand_vld ? w_cand : 4'd0;
  assign bus.arb_state    = r_state;

endmodule
